// File: rtl/hsv_core_store_pkg.sv
// Shared types for the store-drain slice.
//   store_entry_t   : one committed store (word address, data, byte strobes)
//   drain_state_e   : drain FSM states
//   entry_hit()     : true when a valid source aliases a load word address
package hsv_core_store_pkg;

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } store_entry_t;

   localparam int StoreEntryWidth = $bits(store_entry_t);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_RESP = 2'd2
   } drain_state_e;

   localparam logic [1:0] BRESP_OKAY = 2'b00;

   // A store with no strobes writes nothing, so it can never alias a load.
   function automatic logic entry_hit(input logic         vld,
                                      input store_entry_t e,
                                      input logic [29:0]  qaddr);
      return vld & (e.addr == qaddr) & (|e.strb);
   endfunction

endpackage

// File: rtl/hsv_core_store_hazard_cam.sv
// Load-hazard lookup across every place a pending store can live.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   query_valid_i/addr_i load word-address query
//   peek_valid_i/window_i queue slots behind the queue output
//   in_valid_i/entry_i   queue output register
//   held_valid_i/entry_i store currently being drained
//   hazard_valid_o       query_valid_i delayed one cycle
//   hazard_o             registered hit result
module hsv_core_store_hazard_cam
   import hsv_core_store_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     query_valid_i,
   input  logic [29:0]              query_addr_i,
   input  logic [DEPTH-1:0]         peek_valid_i,
   input  store_entry_t [DEPTH-1:0] peek_window_i,
   input  logic                     in_valid_i,
   input  store_entry_t             in_entry_i,
   input  logic                     held_valid_i,
   input  store_entry_t             held_entry_i,
   output logic                     hazard_valid_o,
   output logic                     hazard_o
);

   logic [DEPTH+1:0] src_hit;
   logic [DEPTH+1:0] unused_data;
   logic             hazard_valid_q, hazard_q;

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      assign src_hit[i]     = entry_hit(peek_valid_i[i], peek_window_i[i], query_addr_i);
      assign unused_data[i] = ^peek_window_i[i].data;
   end

   // The output register has left the peek window, so it is compared separately.
   assign src_hit[DEPTH]       = entry_hit(in_valid_i, in_entry_i, query_addr_i);
   assign src_hit[DEPTH+1]     = entry_hit(held_valid_i, held_entry_i, query_addr_i);
   assign unused_data[DEPTH]   = ^in_entry_i.data;
   assign unused_data[DEPTH+1] = ^held_entry_i.data;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         hazard_valid_q <= 1'b0;
         hazard_q       <= 1'b0;
      end else begin
         hazard_valid_q <= query_valid_i;
         hazard_q       <= query_valid_i & (|src_hit);
      end
   end

   assign hazard_valid_o = hazard_valid_q;
   assign hazard_o       = hazard_q;

endmodule

// File: rtl/hsv_core_store_drain.sv
// Drains committed stores from the store queue as single-beat AW/W/B writes
// and answers load-hazard queries.
// Ports:
//   clk_core, rst_core_n        clock, synchronous active-low reset
//   in_ready_o/in_valid_i/in_entry  queue output pop handshake
//   peek_valid_i/peek_window_i  queue slot occupancy and contents
//   aw*, w*, b*                 write address / data / response channels
//   query_valid_i/query_addr_i  load-hazard query
//   hazard_valid_o/hazard_o     registered query result
//   idle_o                      nothing pending anywhere (fence support)
//   err_o                       sticky non-OKAY write response
module hsv_core_store_drain
   import hsv_core_store_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_core,
   input  logic                     rst_core_n,
   output logic                     in_ready_o,
   input  logic                     in_valid_i,
   input  store_entry_t             in_entry,
   input  logic [DEPTH-1:0]         peek_valid_i,
   input  store_entry_t [DEPTH-1:0] peek_window_i,
   output logic                     awvalid_o,
   input  logic                     awready_i,
   output logic [31:0]              awaddr_o,
   output logic                     wvalid_o,
   input  logic                     wready_i,
   output logic [31:0]              wdata_o,
   output logic [3:0]               wstrb_o,
   input  logic                     bvalid_i,
   output logic                     bready_o,
   input  logic [1:0]               bresp_i,
   input  logic                     query_valid_i,
   input  logic [29:0]              query_addr_i,
   output logic                     hazard_valid_o,
   output logic                     hazard_o,
   output logic                     idle_o,
   output logic                     err_o
);

   drain_state_e state_q, state_d;
   store_entry_t held_q, held_d;
   logic         aw_done_q, aw_done_d;
   logic         w_done_q, w_done_d;
   logic         err_q, err_d;

   always_ff @(posedge clk_core) begin
      if (!rst_core_n) begin
         state_q   <= ST_IDLE;
         held_q    <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         held_q    <= held_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      held_d     = held_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      err_d      = err_q;
      in_ready_o = 1'b0;
      awvalid_o  = 1'b0;
      wvalid_o   = 1'b0;
      bready_o   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               held_d    = in_entry;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = ST_SEND;
            end
         end
         ST_SEND: begin
            // AW and W retire independently; the next-state flags cover
            // the case where both handshake in the same cycle.
            awvalid_o = ~aw_done_q;
            wvalid_o  = ~w_done_q;
            if (awvalid_o && awready_i) aw_done_d = 1'b1;
            if (wvalid_o && wready_i)   w_done_d  = 1'b1;
            if (aw_done_d && w_done_d)  state_d   = ST_RESP;
         end
         ST_RESP: begin
            bready_o = 1'b1;
            if (bvalid_i) begin
               state_d = ST_IDLE;
               // Failed stores are reported, not retried.
               if (bresp_i != BRESP_OKAY) err_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign awaddr_o = {held_q.addr, 2'b00};
   assign wdata_o  = held_q.data;
   assign wstrb_o  = held_q.strb;
   assign err_o    = err_q;
   assign idle_o   = (state_q == ST_IDLE) & ~in_valid_i & ~(|peek_valid_i);

   hsv_core_store_hazard_cam #(
      .DEPTH (DEPTH)
   ) u_hazard_cam (
      .clk_i          (clk_core),
      .rst_ni         (rst_core_n),
      .query_valid_i  (query_valid_i),
      .query_addr_i   (query_addr_i),
      .peek_valid_i   (peek_valid_i),
      .peek_window_i  (peek_window_i),
      .in_valid_i     (in_valid_i),
      .in_entry_i     (in_entry),
      .held_valid_i   (state_q != ST_IDLE),
      .held_entry_i   (held_q),
      .hazard_valid_o (hazard_valid_o),
      .hazard_o       (hazard_o)
   );

endmodule

// File: tb/tb_hsv_core_store_drain.sv
// Bench for hsv_core_store_drain: a queue/memory model drives the DUT; every
// store ever pushed is kept in order, and anything not yet B-acknowledged is
// pending for hazard and idle purposes.
module tb_hsv_core_store_drain;
   import hsv_core_store_pkg::*;

   localparam int DEPTH = 4;

   logic clk_core = 1'b0;
   logic rst_core_n = 1'b0;
   always #5 clk_core = ~clk_core;

   logic                     in_ready_o, in_valid_i;
   store_entry_t             in_entry;
   logic [DEPTH-1:0]         peek_valid_i;
   store_entry_t [DEPTH-1:0] peek_window_i;
   logic                     awvalid_o, awready_i, wvalid_o, wready_i;
   logic [31:0]              awaddr_o, wdata_o;
   logic [3:0]               wstrb_o;
   logic                     bvalid_i, bready_o;
   logic [1:0]               bresp_i;
   logic                     query_valid_i;
   logic [29:0]              query_addr_i;
   logic                     hazard_valid_o, hazard_o, idle_o, err_o;

   hsv_core_store_drain #(.DEPTH(DEPTH)) dut (
      .clk_core(clk_core), .rst_core_n(rst_core_n),
      .in_ready_o(in_ready_o), .in_valid_i(in_valid_i), .in_entry(in_entry),
      .peek_valid_i(peek_valid_i), .peek_window_i(peek_window_i),
      .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
      .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
      .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
      .query_valid_i(query_valid_i), .query_addr_i(query_addr_i),
      .hazard_valid_o(hazard_valid_o), .hazard_o(hazard_o),
      .idle_o(idle_o), .err_o(err_o)
   );

   int checks = 0, errors = 0;
   store_entry_t fifo[$];
   store_entry_t sent[$];
   int acc_cnt, aw_cnt, w_cnt, b_cnt, since_acc;
   int aw_wait, w_wait, b_wait;
   int aw_lat, w_lat, b_lat, err_idx;
   bit rnd, tchk;
   bit err_exp, hv_exp, hz_exp;
   bit q_en;
   logic [29:0] q_addr;
   bit prev_aw_pend, prev_w_pend;
   logic [31:0] prev_awaddr, prev_wdata, last_awaddr, last_wdata;
   logic [3:0]  prev_wstrb, last_wstrb;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit pend_hit(input logic [29:0] a);
      for (int j = b_cnt; j < sent.size(); j++)
         if (sent[j].addr == a && sent[j].strb != 4'h0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      fifo.delete(); sent.delete();
      acc_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; since_acc = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0;
      err_exp = 0; hv_exp = 0; hz_exp = 0;
      prev_aw_pend = 0; prev_w_pend = 0;
   endtask

   task automatic push(input logic [29:0] a, input logic [31:0] d, input logic [3:0] s);
      store_entry_t e;
      e.addr = a; e.data = d; e.strb = s;
      fifo.push_back(e);
      sent.push_back(e);
   endtask

   task automatic step();
      bit aw_hs, w_hs, b_hs, acc, both, hv_n, hz_n;
      @(negedge clk_core);
      in_valid_i = fifo.size() > 0;
      in_entry   = in_valid_i ? fifo[0] : '0;
      for (int i = 0; i < DEPTH; i++) begin
         peek_valid_i[i]  = fifo.size() > i + 1;
         peek_window_i[i] = peek_valid_i[i] ? fifo[i+1] : '0;
      end
      awready_i = rnd ? 1'($urandom_range(0, 1)) : (aw_wait >= aw_lat);
      wready_i  = rnd ? 1'($urandom_range(0, 1)) : (w_wait >= w_lat);
      both      = (aw_cnt > b_cnt) && (w_cnt > b_cnt);
      bvalid_i  = both && (rnd ? ($urandom_range(0, 1) == 1) : (b_wait >= b_lat));
      bresp_i   = 2'b00;
      if (bvalid_i && (rnd ? ($urandom_range(0, 7) == 0) : (b_cnt == err_idx))) bresp_i = 2'b10;
      query_valid_i = q_en;
      query_addr_i  = q_addr;
      #1;
      chk("in_ready", in_ready_o, acc_cnt == b_cnt);
      chk("awvalid", awvalid_o, acc_cnt > aw_cnt);
      chk("wvalid", wvalid_o, acc_cnt > w_cnt);
      chk("bready", bready_o, (acc_cnt > b_cnt) && (aw_cnt == acc_cnt) && (w_cnt == acc_cnt));
      chk("idle", idle_o, sent.size() == b_cnt);
      chk("err", err_o, err_exp);
      chk("hz_valid", hazard_valid_o, hv_exp);
      if (hv_exp) chk("hazard", hazard_o, hz_exp);
      if (prev_aw_pend && awvalid_o) chk("aw_stable", awaddr_o, prev_awaddr);
      if (prev_w_pend && wvalid_o) begin
         chk("wdata_stable", wdata_o, prev_wdata);
         chk("wstrb_stable", wstrb_o, prev_wstrb);
      end
      aw_hs = awvalid_o && awready_i;
      w_hs  = wvalid_o && wready_i;
      b_hs  = bvalid_i && bready_o;
      acc   = in_ready_o && in_valid_i;
      if (aw_hs) begin
         chk("aw_order", aw_cnt, acc_cnt - 1);
         if (aw_cnt < sent.size()) chk("awaddr", awaddr_o, {sent[aw_cnt].addr, 2'b00});
         if (tchk) chk("aw_timing", since_acc, aw_lat + 1);
         last_awaddr = awaddr_o;
      end
      if (w_hs) begin
         chk("w_order", w_cnt, acc_cnt - 1);
         if (w_cnt < sent.size()) begin
            chk("wdata", wdata_o, sent[w_cnt].data);
            chk("wstrb", wstrb_o, sent[w_cnt].strb);
         end
         if (tchk) chk("w_timing", since_acc, w_lat + 1);
         last_wdata = wdata_o;
         last_wstrb = wstrb_o;
      end
      if (acc) chk("accept_idle", acc_cnt, b_cnt);
      hv_n = q_en;
      hz_n = q_en && pend_hit(q_addr);
      prev_aw_pend = awvalid_o && !awready_i;
      prev_awaddr  = awaddr_o;
      prev_w_pend  = wvalid_o && !wready_i;
      prev_wdata   = wdata_o;
      prev_wstrb   = wstrb_o;
      @(posedge clk_core);
      if (acc) begin
         void'(fifo.pop_front());
         acc_cnt++;
         since_acc = 1;
      end else since_acc++;
      if (aw_hs) begin aw_cnt++; aw_wait = 0; end
      else if (awvalid_o) aw_wait++;
      if (w_hs) begin w_cnt++; w_wait = 0; end
      else if (wvalid_o) w_wait++;
      if (b_hs) begin
         b_cnt++; b_wait = 0;
         if (bresp_i != 2'b00) err_exp = 1;
      end else if (both) b_wait++;
      hv_exp = hv_n;
      hz_exp = hz_n;
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && sent.size() != b_cnt; i++) step();
      chk("drain_done", b_cnt, sent.size());
      step();
   endtask

   int qa[5] = '{32'h10, 32'h30, 32'h40, 32'h50, 32'h60};
   bit qe[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      in_valid_i = 0; in_entry = '0; peek_valid_i = '0; peek_window_i = '0;
      awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 2'b00;
      query_valid_i = 0; query_addr_i = '0;
      model_reset();
      rnd = 0; tchk = 1; aw_lat = 0; w_lat = 0; b_lat = 0; err_idx = -1;
      q_en = 0; q_addr = '0;
      repeat (2) @(posedge clk_core);
      #1;
      chk("rst_awvalid", awvalid_o, 1'b0);
      chk("rst_wvalid", wvalid_o, 1'b0);
      chk("rst_bready", bready_o, 1'b0);
      chk("rst_hzv", hazard_valid_o, 1'b0);
      chk("rst_hz", hazard_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_in_ready", in_ready_o, 1'b1);
      chk("rst_idle", idle_o, 1'b1);
      @(negedge clk_core);
      rst_core_n = 1;

      // Single store, everything ready immediately.
      push(30'h100, 32'hDEADBEEF, 4'hF);
      drain();
      chk("t1_awaddr", last_awaddr, 32'h400);
      chk("t1_wdata", last_wdata, 32'hDEADBEEF);
      chk("t1_wstrb", last_wstrb, 4'hF);

      // W completes at once, AW waits four cycles.
      aw_lat = 4;
      push(30'h100, 32'h12345678, 4'h3);
      drain();
      chk("t2_awaddr", last_awaddr, 32'h400);
      aw_lat = 0;

      // Back-to-back, with W now the slow channel.
      w_lat = 2;
      push(30'h1, 32'hA1, 4'h1);
      push(30'h2, 32'hA2, 4'h2);
      push(30'h3, 32'hA3, 4'h4);
      drain();
      chk("b2b_aw", aw_cnt, sent.size());
      chk("b2b_w", w_cnt, sent.size());
      w_lat = 0;

      // Hazard: held 0x30, in_entry 0x40, slots 0x10, 0x20, 0x60(strb 0).
      tchk = 0; aw_lat = 30;
      push(30'h30, 32'h30, 4'hF);
      for (int i = 0; i < 5 && acc_cnt == b_cnt; i++) step();
      push(30'h40, 32'h40, 4'hF);
      push(30'h10, 32'h10, 4'h1);
      push(30'h20, 32'h20, 4'h8);
      push(30'h60, 32'h60, 4'h0);
      for (int k = 0; k < 5; k++) begin
         q_en = 1; q_addr = 30'(qa[k]);
         step();
         q_en = 0;
         #1;
         chk("hz_dir", hazard_o, qe[k]);
      end
      aw_lat = 0;
      drain();
      tchk = 1;

      // Error on the second of three stores.
      err_idx = sent.size() + 1;
      push(30'h7, 32'h7, 4'hF);
      push(30'h8, 32'h8, 4'hF);
      push(30'h9, 32'h9, 4'hF);
      drain();
      chk("err_sticky", err_o, 1'b1);
      chk("err_third_done", last_wdata, 32'h9);
      err_idx = -1;

      // Randomised traffic, readies and queries.
      rnd = 1; tchk = 0;
      for (int c = 0; c < 800; c++) begin
         if (fifo.size() < DEPTH + 1 && $urandom_range(0, 2) == 0)
            push(30'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom));
         q_en = $urandom_range(0, 1) == 1;
         q_addr = 30'($urandom_range(0, 7));
         step();
      end
      q_en = 0; rnd = 0;
      drain();

      // Reset while a store is in SEND.
      aw_lat = 30;
      push(30'h77, 32'h77, 4'hF);
      for (int i = 0; i < 5 && acc_cnt == b_cnt; i++) step();
      step();
      @(negedge clk_core);
      rst_core_n = 0;
      fifo.delete();
      in_valid_i = 0; peek_valid_i = '0; awready_i = 0; wready_i = 0;
      bvalid_i = 0; query_valid_i = 0;
      @(posedge clk_core);
      #1;
      chk("rst2_awvalid", awvalid_o, 1'b0);
      chk("rst2_wvalid", wvalid_o, 1'b0);
      chk("rst2_bready", bready_o, 1'b0);
      chk("rst2_err", err_o, 1'b0);
      chk("rst2_in_ready", in_ready_o, 1'b1);
      chk("rst2_hzv", hazard_valid_o, 1'b0);
      @(negedge clk_core);
      rst_core_n = 1;
      model_reset();
      aw_lat = 0; tchk = 1;
      push(30'h55, 32'hCAFEF00D, 4'hC);
      drain();
      chk("post_rst_awaddr", last_awaddr, 32'h154);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
